script_sequencer: RTL and testbench

//  Parametrised successor to the single-step script analyser: fetches one script word per step from the

---
 rtl/script_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_script_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/script_sequencer.sv
// script_sequencer
// Fetches one script word per step from a synchronous script ROM, decodes it and executes
// action, jump, wait and game/end instructions. Supports free-run and single-step operation,
// conditional jumps on kitchen feedback, and timed or feedback-driven waits.
//
// Script word fields: i_num=[15:8], i_sign=[7:5], func=[4:3], op_code=[2:0].
//
// Ports:
//   clk           system clock
//   res           asynchronous reset, active-high
//   script        ROM data for address pc, valid one cycle after pc changes
//   run           1 = free-run, 0 = single-step (sampled only in IDLE)
//   step          one-cycle pulse starting one instruction in single-step mode
//   feedback_sig  kitchen feedback used by conditional jumps and feedback waits
//   act_done      one-cycle pulse from the action consumer, honoured only in ACT
//   pc            current script address
//   act_valid     action request, held until act_done
//   act_num       i_num of the current action
//   act_func      func of the current action
//   busy          high in any state other than IDLE/HALT
//   halted        high in HALT
//   err           sticky illegal-opcode flag
module script_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned PC_STEP  = 2,
  parameter int unsigned WAIT_W   = 16,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic               clk,
  input  logic               res,
  input  logic [INSTR_W-1:0] script,
  input  logic               run,
  input  logic               step,
  input  logic               feedback_sig,
  input  logic               act_done,
  output logic [PC_W-1:0]    pc,
  output logic               act_valid,
  output logic [7:0]         act_num,
  output logic [1:0]         act_func,
  output logic               busy,
  output logic               halted,
  output logic               err
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StAct    = 3'd3;
  localparam logic [2:0] StWait   = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [2:0] OpAction = 3'b001;
  localparam logic [2:0] OpJump   = 3'b010;
  localparam logic [2:0] OpWait   = 3'b011;
  localparam logic [2:0] OpEnd    = 3'b100;

  // Product of an 8-bit i_num and a 32-bit divider always fits in 40 bits.
  localparam int unsigned ProdW   = 40;
  localparam logic [ProdW-1:0] WaitMax = {{(ProdW-WAIT_W){1'b0}}, {WAIT_W{1'b1}}};

  logic [2:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              act_valid_q, act_valid_d;
  logic [7:0]        act_num_q, act_num_d;
  logic [1:0]        act_func_q, act_func_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  // Only the wait mode of the decoded word is needed after DECODE.
  logic              wait_fb_q, wait_fb_d;

  logic [7:0]        i_num;
  logic [2:0]        i_sign;
  logic [1:0]        func;
  logic [2:0]        op_code;
  logic [PC_W-1:0]   pc_inc;
  logic [ProdW-1:0]  wait_prod;
  logic [WAIT_W-1:0] wait_load;
  logic              jump_taken;
  logic              unused_script;

  assign i_num   = script[15:8];
  assign i_sign  = script[7:5];
  assign func    = script[4:3];
  assign op_code = script[2:0];

  // i_sign[2] and any bits above 15 carry no meaning.
  assign unused_script = ^script;

  assign pc_inc     = pc_q + PC_W'(PC_STEP);
  assign jump_taken = !i_sign[0] || (feedback_sig == i_sign[1]);

  assign wait_prod = ProdW'(i_num) * ProdW'(TICK_DIV);

  always_comb begin
    wait_load = '1;
    if (wait_prod <= WaitMax) begin
      wait_load = wait_prod[WAIT_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    act_valid_d = act_valid_q;
    act_num_d   = act_num_q;
    act_func_d  = act_func_q;
    err_d       = err_q;
    wait_cnt_d  = wait_cnt_q;
    wait_fb_d   = wait_fb_q;

    case (state_q)
      StIdle: begin
        if (run || step) begin
          state_d = StFetch;
        end
      end

      // ROM read latency is absorbed here.
      StFetch: begin
        state_d = StDecode;
      end

      StDecode: begin
        case (op_code)
          OpAction: begin
            act_valid_d = 1'b1;
            act_num_d   = i_num;
            act_func_d  = func;
            state_d     = StAct;
          end
          OpJump: begin
            pc_d    = jump_taken ? PC_W'(i_num) : pc_inc;
            state_d = StIdle;
          end
          OpWait: begin
            if (func == 2'b00 && i_num != 8'd0) begin
              // Counter runs load-1 .. 0 so WAIT lasts exactly wait_load cycles.
              wait_cnt_d = wait_load - WAIT_W'(1);
              wait_fb_d  = 1'b0;
              state_d    = StWait;
            end else if (func == 2'b01) begin
              wait_fb_d = 1'b1;
              state_d   = StWait;
            end else begin
              pc_d    = pc_inc;
              state_d = StIdle;
            end
          end
          OpEnd: begin
            state_d = StHalt;
          end
          default: begin
            err_d   = 1'b1;
            state_d = StHalt;
          end
        endcase
      end

      StAct: begin
        if (act_done) begin
          act_valid_d = 1'b0;
          pc_d        = pc_inc;
          state_d     = StIdle;
        end
      end

      StWait: begin
        if (wait_fb_q) begin
          if (feedback_sig) begin
            pc_d    = pc_inc;
            state_d = StIdle;
          end
        end else if (wait_cnt_q == '0) begin
          pc_d    = pc_inc;
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      // Only reset leaves HALT.
      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      act_valid_q <= 1'b0;
      act_num_q   <= '0;
      act_func_q  <= '0;
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
      wait_fb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      act_valid_q <= act_valid_d;
      act_num_q   <= act_num_d;
      act_func_q  <= act_func_d;
      err_q       <= err_d;
      wait_cnt_q  <= wait_cnt_d;
      wait_fb_q   <= wait_fb_d;
    end
  end

  assign pc        = pc_q;
  assign act_valid = act_valid_q;
  assign act_num   = act_num_q;
  assign act_func  = act_func_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle) && (state_q != StHalt);
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_script_sequencer.sv
// Self-checking bench for script_sequencer: a table of single-instruction vectors executed
// from reset in single-step mode, plus hand-written multi-cycle sequences.
module tb_script_sequencer;

  logic        clk;
  logic        res;
  logic [15:0] script;
  logic        run;
  logic        step;
  logic        feedback_sig;
  logic        act_done;
  logic [7:0]  pc;
  logic        act_valid;
  logic [7:0]  act_num;
  logic [1:0]  act_func;
  logic        busy;
  logic        halted;
  logic        err;

  logic [15:0] rom [256];

  int total;
  int bad;

  script_sequencer #(
    .PC_W    (8),
    .INSTR_W (16),
    .PC_STEP (2),
    .WAIT_W  (8),
    .TICK_DIV(4)
  ) dut (
    .clk         (clk),
    .res         (res),
    .script      (script),
    .run         (run),
    .step        (step),
    .feedback_sig(feedback_sig),
    .act_done    (act_done),
    .pc          (pc),
    .act_valid   (act_valid),
    .act_num     (act_num),
    .act_func    (act_func),
    .busy        (busy),
    .halted      (halted),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous script ROM: data for pc appears one cycle after pc is presented.
  always_ff @(posedge clk) begin
    script <= rom[pc];
  end

  typedef struct {
    logic [15:0] instr;
    logic        fb;
    logic [7:0]  exp_pc;
    int          exp_cyc;  // cycles with busy=1 after the step
    logic        exp_halted;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    res = 1'b1;
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Step once, then count cycles until busy drops (bounded).
  task automatic run_one(output int cyc);
    pulse_step();
    cyc = 0;
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      cyc++;
      @(negedge clk);
    end
  endtask

  // Wait for act_valid; returns number of negedges waited, or -1 on timeout.
  task automatic wait_act(output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (act_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    int lat;
    total = 0;
    bad   = 0;

    //                instr     fb    pc     cyc  halt  err
    vecs[0]  = '{16'h0802, 1'b0, 8'h08, 2,   1'b0, 1'b0};  // unconditional jump
    vecs[1]  = '{16'h0822, 1'b1, 8'h02, 2,   1'b0, 1'b0};  // cond on fb==0, fb=1: not taken
    vecs[2]  = '{16'h0822, 1'b0, 8'h08, 2,   1'b0, 1'b0};  // cond on fb==0, fb=0: taken
    vecs[3]  = '{16'h0862, 1'b1, 8'h08, 2,   1'b0, 1'b0};  // cond on fb==1, fb=1: taken
    vecs[4]  = '{16'h0303, 1'b0, 8'h02, 14,  1'b0, 1'b0};  // timed wait 3*4 cycles
    vecs[5]  = '{16'h0003, 1'b0, 8'h02, 2,   1'b0, 1'b0};  // timed wait i_num=0: nop
    vecs[6]  = '{16'h000B, 1'b1, 8'h02, 3,   1'b0, 1'b0};  // feedback wait, fb already high
    vecs[7]  = '{16'h0513, 1'b0, 8'h02, 2,   1'b0, 1'b0};  // wait func=1x: nop
    vecs[8]  = '{16'h6403, 1'b0, 8'h02, 257, 1'b0, 1'b0};  // 100*4 saturates to 255
    vecs[9]  = '{16'h0004, 1'b0, 8'h00, 2,   1'b1, 1'b0};  // end
    vecs[10] = '{16'h0007, 1'b0, 8'h00, 2,   1'b1, 1'b1};  // illegal 111
    vecs[11] = '{16'hFF02, 1'b0, 8'hFF, 2,   1'b0, 1'b0};  // jump to top address

    res          = 1'b1;
    run          = 1'b0;
    step         = 1'b0;
    feedback_sig = 1'b0;
    act_done     = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0004;
    repeat (2) @(negedge clk);

    check("rst_pc", 32'(pc), 32'h0);
    check("rst_act_valid", 32'(act_valid), 32'h0);
    check("rst_act_num", 32'(act_num), 32'h0);
    check("rst_act_func", 32'(act_func), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    res = 1'b0;

    // Table-driven single instructions.
    for (int i = 0; i < 12; i++) begin
      rom[0]       = vecs[i].instr;
      feedback_sig = vecs[i].fb;
      do_reset();
      run_one(cyc);
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      check($sformatf("v%0d_cyc", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      feedback_sig = 1'b0;
    end

    // Single-step action with handshake.
    rom[0] = 16'h0509;
    do_reset();
    pulse_step();
    wait_act(lat);
    check("act_latency", 32'(lat), 32'd2);
    repeat (3) @(negedge clk);
    check("act_hold_valid", 32'(act_valid), 32'h1);
    check("act_num", 32'(act_num), 32'h05);
    check("act_func", 32'(act_func), 32'h1);
    check("act_busy", 32'(busy), 32'h1);
    check("act_pc_before", 32'(pc), 32'h0);
    act_done = 1'b1;
    @(negedge clk);
    act_done = 1'b0;
    check("act_done_valid", 32'(act_valid), 32'h0);
    check("act_done_pc", 32'(pc), 32'h2);
    check("act_done_busy", 32'(busy), 32'h0);
    act_done = 1'b1;
    @(negedge clk);
    act_done = 1'b0;
    @(negedge clk);
    check("act_done_idle_pc", 32'(pc), 32'h2);

    // Free-run: jump to 8, then end at 8; steps ignored once halted.
    rom[0] = 16'h0802;
    rom[8] = 16'h0004;
    do_reset();
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("run_jump_pc", 32'(pc), 32'h08);
    for (int k = 0; k < 20; k++) begin
      if (halted) break;
      @(negedge clk);
    end
    check("run_halted", 32'(halted), 32'h1);
    check("run_halt_pc", 32'(pc), 32'h08);
    run = 1'b0;
    pulse_step();
    repeat (4) @(negedge clk);
    check("halt_step_halted", 32'(halted), 32'h1);
    check("halt_step_pc", 32'(pc), 32'h08);
    check("halt_step_busy", 32'(busy), 32'h0);

    // Feedback wait holds while feedback is low; step in WAIT is dropped.
    rom[0] = 16'h000B;
    rom[2] = 16'h0802;
    do_reset();
    pulse_step();
    repeat (8) @(negedge clk);
    check("fbw_busy", 32'(busy), 32'h1);
    check("fbw_pc", 32'(pc), 32'h0);
    pulse_step();
    feedback_sig = 1'b1;
    @(negedge clk);
    feedback_sig = 1'b0;
    check("fbw_exit_pc", 32'(pc), 32'h2);
    check("fbw_exit_busy", 32'(busy), 32'h0);
    repeat (5) @(negedge clk);
    check("fbw_step_dropped_pc", 32'(pc), 32'h2);

    // Asynchronous reset in the middle of ACT.
    rom[0] = 16'h0802;
    rom[8] = 16'h0509;
    do_reset();
    run_one(cyc);
    check("mid_pc8", 32'(pc), 32'h08);
    pulse_step();
    wait_act(lat);
    check("mid_act_seen", 32'(act_valid), 32'h1);
    #2;
    res = 1'b1;
    #1;
    check("mid_res_valid", 32'(act_valid), 32'h0);
    check("mid_res_pc", 32'(pc), 32'h0);
    check("mid_res_busy", 32'(busy), 32'h0);
    @(negedge clk);
    res = 1'b0;

    // pc wraps modulo 256.
    rom[0]   = 16'hFE02;
    rom[254] = 16'h0003;
    do_reset();
    run_one(cyc);
    check("wrap_pre_pc", 32'(pc), 32'hFE);
    run_one(cyc);
    check("wrap_pc", 32'(pc), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
